// File: rtl/fp_max_search.sv
// fp_max_search: streams len words out of a sync-read buffer and keeps the
// running maximum above a threshold. The data are sign-magnitude fixed point.
// It returns the peak value, the index of that peak and a found flag.
module fp_max_search #(
    parameter int Q  = 16,
    parameter int N  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic [N-1:0]  thresh,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_data,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [N-1:0]  max_val,
    output logic [AW-1:0] max_idx
);

    // Q only positions the binary point. Ordering in sign-magnitude does not
    // depend on it, so it is only range-checked here.
    if (Q < 0 || Q > N - 1) begin : g_bad_q
        $error("fp_max_search: Q must lie in 0..N-1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sign-magnitude strict greater-than.
    // +0 ranks above -0, and a larger magnitude ranks lower among negatives.
    function automatic logic gt(input logic [N-1:0] a, input logic [N-1:0] b);
        logic res;
        if (a == b) begin
            res = 1'b0;
        end else if (a[N-1] != b[N-1]) begin
            res = ~a[N-1];
        end else if (!a[N-1]) begin
            res = (a[N-2:0] > b[N-2:0]);
        end else begin
            res = ~(a[N-2:0] > b[N-2:0]);
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] addr_q, addr_d;
    // Tracks which address the word on mem_data belongs to, one cycle behind the read.
    logic          vld_q, vld_d;
    logic [AW-1:0] jdx_q, jdx_d;
    // Running maximum.
    logic [N-1:0]  cur_q, cur_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          cfound_q, cfound_d;
    // Published results. They hold until the next DONE.
    logic          found_q, found_d;
    logic [N-1:0]  maxv_q, maxv_d;
    logic [AW-1:0] maxi_q, maxi_d;

    // Next-state, read sequencing and running-maximum update.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_en_d  = rd_en_q;
        addr_d   = addr_q;
        vld_d    = rd_en_q;
        jdx_d    = addr_q;
        cur_d    = cur_q;
        idx_d    = idx_q;
        cfound_d = cfound_q;
        found_d  = found_q;
        maxv_d   = maxv_q;
        maxi_d   = maxi_q;

        // Compare stage: the word read last cycle is checked against the running max.
        // The update is strict, so on a tie the earlier index is kept.
        if (vld_q && gt(mem_data, cur_q)) begin
            cur_d    = mem_data;
            idx_d    = jdx_q;
            cfound_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    cur_d    = thresh;
                    idx_d    = '0;
                    cfound_d = 1'b0;
                    if (len == '0) begin
                        state_d = DONE;
                        found_d = 1'b0;
                        maxv_d  = '0;
                        maxi_d  = '0;
                    end else begin
                        state_d = RUN;
                        rd_en_d = 1'b1;
                        addr_d  = '0;
                    end
                end
            end
            RUN: begin
                if (addr_q == len_q - AW'(1)) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            DRAIN: begin
                // The last word is evaluated this cycle. Publish the post-update values
                // so the results are valid while done is high.
                state_d = DONE;
                found_d = cfound_d;
                maxv_d  = cfound_d ? cur_d : '0;
                maxi_d  = cfound_d ? idx_d : '0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. An async reset aborts the run and clears the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            vld_q    <= 1'b0;
            jdx_q    <= '0;
            cur_q    <= '0;
            idx_q    <= '0;
            cfound_q <= 1'b0;
            found_q  <= 1'b0;
            maxv_q   <= '0;
            maxi_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            vld_q    <= vld_d;
            jdx_q    <= jdx_d;
            cur_q    <= cur_d;
            idx_q    <= idx_d;
            cfound_q <= cfound_d;
            found_q  <= found_d;
            maxv_q   <= maxv_d;
            maxi_q   <= maxi_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign found     = found_q;
    assign max_val   = maxv_q;
    assign max_idx   = maxi_q;

endmodule

// File: tb/tb_fp_max_search.sv
// Testbench for fp_max_search: directed cases plus randomized runs checked against
// a reference model that ranks sign-magnitude words by an integer key.
module tb_fp_max_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [31:0] thresh;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        busy, done, found;
    logic [31:0] max_val;
    logic [7:0]  max_idx;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    int          o_done_cyc, o_rd_cnt, o_rd_bad, o_busy_bad;
    logic        o_found;
    logic [31:0] o_val;
    logic [7:0]  o_idx;

    fp_max_search #(.Q(16), .N(32), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .thresh(thresh),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .found(found), .max_val(max_val), .max_idx(max_idx)
    );

    always #5 clk = ~clk;

    // Sync-read buffer: data appear the cycle after the read strobe.
    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

    // Ordering key: -0 -> -1, +0 -> 0, and negatives fall below every non-negative value.
    function automatic longint key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -(2 * m + 1) : 2 * m;
    endfunction

    task automatic model(input int n, input logic [31:0] th,
                         output logic f, output logic [31:0] v, output logic [7:0] i);
        logic [31:0] cur;
        cur = th; f = 1'b0; i = 8'd0;
        for (int j = 0; j < n; j++) begin
            if (key(mem[j]) > key(cur)) begin
                cur = mem[j]; i = 8'(j); f = 1'b1;
            end
        end
        v = f ? cur : 32'd0;
        if (!f) i = 8'd0;
    endtask

    function automatic logic [31:0] rnd_word(input logic [31:0] prev);
        logic [31:0] w;
        case ($urandom_range(0, 5))
            0: w = $urandom;
            1: w = 32'h0000_0000;
            2: w = 32'h8000_0000;
            3: w = {1'b0, 27'd0, 4'($urandom)};
            4: w = {1'b1, 27'd0, 4'($urandom)};
            default: w = prev;
        endcase
        return w;
    endfunction

    // Drives a start with hold_c giving an extra start pulse in that cycle (0 = none).
    // Records the read sequence, the busy level and the result seen at done.
    task automatic do_run(input int n, input logic [31:0] th, input int hold_c);
        @(negedge clk);
        len = 8'(n); thresh = th; start = 1'b1;
        o_done_cyc = -1; o_rd_cnt = 0; o_rd_bad = 0; o_busy_bad = 0;
        o_found = 1'b0; o_val = 32'd0; o_idx = 8'd0;
        for (int c = 1; c <= n + 20; c++) begin
            @(posedge clk); #1;
            start = (c == hold_c);
            if (mem_rd_en === 1'b1) begin
                if (mem_addr !== 8'(o_rd_cnt) || c != o_rd_cnt + 1) o_rd_bad++;
                o_rd_cnt++;
            end
            if (busy !== 1'b1) o_busy_bad++;
            if (done === 1'b1) begin
                o_done_cyc = c; o_found = found; o_val = max_val; o_idx = max_idx;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({mem_rd_en, mem_addr, busy, done, found, max_val, max_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0",
                     {mem_rd_en, mem_addr, busy, done, found, max_val, max_idx});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_tie_first();
        mem[0] = 32'h0001_0000; mem[1] = 32'h0003_0000;
        mem[2] = 32'h8002_0000; mem[3] = 32'h0003_0000;
        do_run(4, 32'h0, 0);
        n_cmp++; if (o_done_cyc !== 6) begin n_err++; $display("FAIL t1_done_cycle got %0d want 6", o_done_cyc); end
        n_cmp++; if (o_found !== 1'b1) begin n_err++; $display("FAIL t1_found got %b want 1", o_found); end
        n_cmp++; if (o_val !== 32'h0003_0000) begin n_err++; $display("FAIL t1_max_val got %h want 00030000", o_val); end
        n_cmp++; if (o_idx !== 8'd1) begin n_err++; $display("FAIL t1_max_idx got %0d want 1", o_idx); end
        n_cmp++; if (o_rd_cnt !== 4 || o_rd_bad !== 0) begin n_err++; $display("FAIL t1_reads got cnt=%0d bad=%0d want cnt=4 bad=0", o_rd_cnt, o_rd_bad); end
        n_cmp++; if (o_busy_bad !== 0) begin n_err++; $display("FAIL t1_busy got %0d low cycles want 0", o_busy_bad); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || max_val !== 32'h0003_0000 || max_idx !== 8'd1) begin
            n_err++;
            $display("FAIL t1_after_done got done=%b busy=%b val=%h idx=%0d want 0 0 00030000 1", done, busy, max_val, max_idx);
        end
    endtask

    task automatic test_negative();
        mem[0] = 32'h8005_0000; mem[1] = 32'h8001_0000; mem[2] = 32'h8003_0000;
        do_run(3, 32'h8008_0000, 0);
        n_cmp++; if (o_found !== 1'b1) begin n_err++; $display("FAIL t2_found got %b want 1", o_found); end
        n_cmp++; if (o_val !== 32'h8001_0000) begin n_err++; $display("FAIL t2_max_val got %h want 80010000", o_val); end
        n_cmp++; if (o_idx !== 8'd1) begin n_err++; $display("FAIL t2_max_idx got %0d want 1", o_idx); end
        n_cmp++; if (o_done_cyc !== 5) begin n_err++; $display("FAIL t2_done_cycle got %0d want 5", o_done_cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_none_found();
        mem[0] = 32'h0001_0000; mem[1] = 32'h0002_0000;
        do_run(2, 32'h0002_0000, 0);
        n_cmp++; if (o_done_cyc !== 4) begin n_err++; $display("FAIL t3_done_cycle got %0d want 4", o_done_cyc); end
        n_cmp++;
        if (o_found !== 1'b0 || o_val !== 32'd0 || o_idx !== 8'd0) begin
            n_err++; $display("FAIL t3_result got found=%b val=%h idx=%0d want 0 0 0", o_found, o_val, o_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len0_back_to_back();
        do_run(0, 32'h0, 0);
        n_cmp++; if (o_done_cyc !== 1) begin n_err++; $display("FAIL t4_done_cycle got %0d want 1", o_done_cyc); end
        n_cmp++; if (o_rd_cnt !== 0) begin n_err++; $display("FAIL t4_reads got %0d want 0", o_rd_cnt); end
        n_cmp++; if (o_found !== 1'b0 || o_val !== 32'd0) begin n_err++; $display("FAIL t4_found got %b val %h want 0 0", o_found, o_val); end
        @(posedge clk); #1;
        mem[0] = 32'h0001_0000; mem[1] = 32'h0003_0000;
        mem[2] = 32'h8002_0000; mem[3] = 32'h0003_0000;
        do_run(4, 32'h0, 0);
        n_cmp++;
        if (o_done_cyc !== 6 || o_val !== 32'h0003_0000 || o_idx !== 8'd1) begin
            n_err++; $display("FAIL t4_back_to_back got cyc=%0d val=%h idx=%0d want 6 00030000 1", o_done_cyc, o_val, o_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed_zero();
        mem[0] = 32'h8000_0000; mem[1] = 32'h0000_0000;
        do_run(2, 32'h8000_0001, 0);
        n_cmp++;
        if (o_found !== 1'b1 || o_val !== 32'h0000_0000 || o_idx !== 8'd1) begin
            n_err++; $display("FAIL t5_zero got found=%b val=%h idx=%0d want 1 00000000 1", o_found, o_val, o_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        logic ef; logic [31:0] ev; logic [7:0] ei;
        for (int j = 0; j < 8; j++) mem[j] = rnd_word(32'h0004_0000);
        model(8, 32'h8000_0000, ef, ev, ei);
        do_run(8, 32'h8000_0000, 2);
        n_cmp++; if (o_rd_cnt !== 8 || o_rd_bad !== 0) begin n_err++; $display("FAIL t6_restart_reads got cnt=%0d bad=%0d want 8 0", o_rd_cnt, o_rd_bad); end
        n_cmp++; if (o_done_cyc !== 10) begin n_err++; $display("FAIL t6_restart_done got %0d want 10", o_done_cyc); end
        n_cmp++;
        if (o_found !== ef || o_val !== ev || o_idx !== ei) begin
            n_err++; $display("FAIL t6_restart_result got %b %h %0d want %b %h %0d", o_found, o_val, o_idx, ef, ev, ei);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int bad;
        mem[0] = 32'h0007_0000;
        for (int j = 1; j < 8; j++) mem[j] = 32'h0001_0000;
        @(negedge clk); len = 8'd8; thresh = 32'h0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({mem_rd_en, mem_addr, busy, done, found, max_val, max_idx} !== '0) begin
            n_err++; $display("FAIL t6_abort_outputs got %h want 0",
                              {mem_rd_en, mem_addr, busy, done, found, max_val, max_idx});
        end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t6_abort_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_random();
        logic ef; logic [31:0] ev; logic [7:0] ei;
        logic [31:0] th, prev;
        int n;
        for (int it = 0; it < 40; it++) begin
            n = (it == 39) ? 255 : $urandom_range(1, 30);
            prev = 32'h0000_0005;
            for (int j = 0; j < n; j++) begin
                mem[j] = rnd_word(prev);
                prev = mem[j];
            end
            th = rnd_word(32'h8000_0003);
            model(n, th, ef, ev, ei);
            do_run(n, th, 0);
            n_cmp++;
            if (o_found !== ef || o_val !== ev || o_idx !== ei) begin
                n_err++; $display("FAIL rnd%0d_result got %b %h %0d want %b %h %0d", it, o_found, o_val, o_idx, ef, ev, ei);
            end
            n_cmp++;
            if (o_done_cyc !== n + 2 || o_rd_cnt !== n || o_rd_bad !== 0) begin
                n_err++; $display("FAIL rnd%0d_timing got cyc=%0d rd=%0d bad=%0d want cyc=%0d rd=%0d bad=0", it, o_done_cyc, o_rd_cnt, o_rd_bad, n + 2, n);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 8'd0; thresh = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        repeat (2) @(posedge clk);
        test_tie_first();
        test_negative();
        test_none_found();
        test_len0_back_to_back();
        test_signed_zero();
        test_ignore_start();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
